seq_calc: RTL and testbench
===========================

SEQ_CALC -- requirements
Module: seq_calc

Interface
REQ-001 Parameter: W, default 16, operand/result width in bits (two's complement), legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; accepted only on a rising edge where busy=0.
REQ-005 OP  input  3  opcode, sampled at acceptance.
REQ-006 A  input  W  operand A, signed, sampled at acceptance.
REQ-007 B  input  W  operand B, signed, sampled at acceptance.
REQ-008 R  output  W  registered result; holds until next completion.
REQ-009 ovf  output  1  registered signed-overflow flag for the last completed op.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while a multiply is in progress.

Function
REQ-012 Opcodes SHALL be: 000 A+B; 001 A-B; 010 abs(A); 011 abs(B); 100 ACC+A; 101 ACC-A; 110 A*B; 111 clear ACC.
REQ-013 FSM states SHALL be IDLE and MUL; IDLE->MUL on accepted start with OP=110; MUL->IDLE after W iteration edges; all other ops stay in IDLE.
REQ-014 busy SHALL be 1 exactly when state=MUL.
REQ-015 Non-multiply ops SHALL update R, ovf, ACC at the accepting edge; done=1 for the following cycle only (latency 1).
REQ-016 Multiply SHALL complete W+1 edges after acceptance (including it); R, ovf updated and done=1 for one cycle after that edge.
REQ-017 Multiply SHALL use a shift-add datapath, one bit per cycle, on operand magnitudes with sign applied at completion; no combinational W x W multiplier.
REQ-018 Multiply R SHALL be low W bits of the exact signed 2W-bit product; ovf=1 iff the product lies outside [-2^(W-1), 2^(W-1)-1].
REQ-019 Add/sub (000, 001, 100, 101) SHALL wrap modulo 2^W; ovf=1 iff the true signed result is unrepresentable.
REQ-020 abs: non-negative operand -> R=operand, ovf=0; negative -> R=-operand; most-negative value -> R=operand unchanged, ovf=1.
REQ-021 ACC: internal W-bit register; 100/101 SHALL write the wrapped result to both ACC and R; 111 SHALL set ACC=0, R=0, ovf=0.
REQ-022 Ops 000-011 and 110 SHALL not modify ACC.
REQ-023 start while busy=1 SHALL be ignored: no queueing, no effect on operands or result.
REQ-024 Operand/opcode changes after acceptance SHALL not affect the in-flight op.
REQ-025 Back-to-back: start SHALL be accepted in the cycle done is high (busy=0); the new op does not disturb the completing result.
REQ-026 R, ovf SHALL hold their values between completions; done=0 except completion pulses.

Reset
REQ-027 rst=1 SHALL immediately, independent of clk, force state=IDLE, R=0, ovf=0, done=0, busy=0, ACC=0, and clear multiplier registers.
REQ-028 rst asserted during MUL SHALL abort the multiply; no done pulse for it after release.
REQ-029 The first start SHALL be accepted on the first rising edge with rst=0.

Verification (W=16)
REQ-030 OP=000, A=0x7FFF, B=0x0001 -> next cycle R=0x8000, ovf=1, done=1 for one cycle, busy=0 throughout.
REQ-031 OP=010, A=0xFFFB -> R=0x0005, ovf=0; then A=0x8000 -> R=0x8000, ovf=1.
REQ-032 OP=110, A=0xFFFD, B=0x0007 -> busy=1 for 16 cycles, done 17 edges after acceptance, R=0xFFEB, ovf=0; then A=B=0x0100 -> R=0x0000, ovf=1.
REQ-033 OP=111; OP=100 A=5 twice; OP=101 A=12 -> R=0x0005, 0x000A, 0xFFFE; ovf=0 each; ACC=0xFFFE.
REQ-034 Start OP=000 during busy -> ignored, multiply result unchanged; start OP=001 A=9 B=4 in the done cycle -> next cycle R=0x0005.
REQ-035 rst pulse mid-multiply (no clock edge) -> busy=0, R=0, ovf=0 at once; no done after release.

Source files
------------

// File: rtl/seq_calc.sv
// Sequential calculator: single-cycle add/sub/abs/accumulate ops and a
// W-cycle shift-add signed multiply, with registered result and overflow flag.
module seq_calc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   OP,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] R,
  output logic         ovf,
  output logic         done,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic IDLE = 1'b0;
  localparam logic MUL  = 1'b1;

  logic           state;
  logic [W-1:0]   acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [W-1:0]   mplier;
  logic           neg;
  logic [CW-1:0]  cnt;

  logic [W:0]     add_ab, sub_ab, add_acc, sub_acc;
  logic [W-1:0]   neg_a, neg_b, mag_a, mag_b;
  logic [2*W-1:0] prod_nx, prod_fin;
  logic           mul_ovf;

  // One extra sign bit: overflow is a disagreement between the top two bits.
  assign add_ab  = {A[W-1], A} + {B[W-1], B};
  assign sub_ab  = {A[W-1], A} - {B[W-1], B};
  assign add_acc = {acc[W-1], acc} + {A[W-1], A};
  assign sub_acc = {acc[W-1], acc} - {A[W-1], A};

  // Negating the most-negative value yields itself, which is still negative.
  assign neg_a = '0 - A;
  assign neg_b = '0 - B;
  assign mag_a = A[W-1] ? neg_a : A;
  assign mag_b = B[W-1] ? neg_b : B;

  assign prod_nx  = prod + (mplier[0] ? mcand : '0);
  assign prod_fin = neg ? ('0 - prod_nx) : prod_nx;
  assign mul_ovf  = ~((&prod_fin[2*W-1:W-1]) | ~(|prod_fin[2*W-1:W-1]));

  assign busy = (state == MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      R      <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            done <= (OP != 3'b110);
            case (OP)
              3'b000: begin R <= add_ab[W-1:0]; ovf <= add_ab[W] ^ add_ab[W-1]; end
              3'b001: begin R <= sub_ab[W-1:0]; ovf <= sub_ab[W] ^ sub_ab[W-1]; end
              3'b010: begin R <= mag_a; ovf <= A[W-1] & neg_a[W-1]; end
              3'b011: begin R <= mag_b; ovf <= B[W-1] & neg_b[W-1]; end
              3'b100: begin
                R   <= add_acc[W-1:0];
                acc <= add_acc[W-1:0];
                ovf <= add_acc[W] ^ add_acc[W-1];
              end
              3'b101: begin
                R   <= sub_acc[W-1:0];
                acc <= sub_acc[W-1:0];
                ovf <= sub_acc[W] ^ sub_acc[W-1];
              end
              3'b110: begin
                state  <= MUL;
                mcand  <= {{W{1'b0}}, mag_a};
                mplier <= mag_b;
                prod   <= '0;
                neg    <= A[W-1] ^ B[W-1];
                cnt    <= '0;
              end
              3'b111: begin R <= '0; acc <= '0; ovf <= 1'b0; end
            endcase
          end
        end
        MUL: begin
          prod   <= prod_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state <= IDLE;
            R     <= prod_fin[W-1:0];
            ovf   <= mul_ovf;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calc.sv
// Randomized self-checking bench for seq_calc (W=16) against an arithmetic
// reference model using wide signed integers.
module tb_seq_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  OP;
  logic [15:0] A, B;
  logic [15:0] R;
  logic        ovf, done, busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] macc;
  logic [15:0] last_r;
  logic        last_ovf;

  seq_calc #(.W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .OP(OP), .A(A), .B(B),
    .R(R), .ovf(ovf), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Exact signed result, then wrap to 16 bits; overflow = out of 16-bit range.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic v);
    longint sa, sb, sc, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sc = longint'($signed(macc));
    case (op)
      3'd0: t = sa + sb;
      3'd1: t = sa - sb;
      3'd2: t = (sa < 0) ? -sa : sa;
      3'd3: t = (sb < 0) ? -sb : sb;
      3'd4: t = sc + sa;
      3'd5: t = sc - sa;
      3'd6: t = sa * sb;
      default: t = 0;
    endcase
    r = 16'(t);
    v = (t > 32767) || (t < -32768);
    if (op == 3'd4 || op == 3'd5 || op == 3'd7) macc = r;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic        ev;
    model(op, a, b, er, ev);
    start = 1'b1; OP = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; OP = 3'($urandom); A = 16'($urandom); B = 16'($urandom);
    if (op == 3'd6) begin
      for (int i = 0; i < 16; i++) begin
        chk("busy", busy, 1);
        chk("done_early", done, 0);
        start = 1'($urandom_range(0, 1));
        OP = 3'($urandom); A = 16'($urandom); B = 16'($urandom);
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("R", R, er);
    chk("ovf", ovf, ev);
    last_r = er;
    last_ovf = ev;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    chk("done_idle", done, 0);
    chk("busy_idle", busy, 0);
    chk("R_hold", R, last_r);
    chk("ovf_hold", ovf, last_ovf);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; OP = '0; A = '0; B = '0;
    macc = '0; last_r = '0; last_ovf = 1'b0;
    #3;
    chk("rst_R", R, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(3'd0, 16'h7FFF, 16'h0001);
    chk("add_ovf_R", R, 16'h8000);
    chk("add_ovf_flag", ovf, 1);
    idle();
    run_op(3'd2, 16'hFFFB, 16'h0000);
    chk("abs_R", R, 16'h0005);
    run_op(3'd2, 16'h8000, 16'h0000);
    chk("abs_min_ovf", ovf, 1);
    run_op(3'd7, 16'h0000, 16'h0000);
    run_op(3'd4, 16'h0005, 16'h0000);
    run_op(3'd4, 16'h0005, 16'h0000);
    run_op(3'd5, 16'h000C, 16'h0000);
    chk("acc_sub_R", R, 16'hFFFE);
    run_op(3'd4, 16'h0000, 16'h0000);
    chk("acc_value", R, 16'hFFFE);
    idle();
    run_op(3'd6, 16'hFFFD, 16'h0007);
    chk("mul_R", R, 16'hFFEB);
    run_op(3'd6, 16'h0100, 16'h0100);
    chk("mul_ovf", ovf, 1);
    run_op(3'd1, 16'h0009, 16'h0004);
    chk("b2b_R", R, 16'h0005);
    idle();

    for (int n = 0; n < 150; n++) begin
      run_op(3'($urandom), pick(), pick());
      if ($urandom_range(0, 3) == 0) idle();
    end

    // Abort a multiply with an asynchronous reset between clock edges.
    start = 1'b1; OP = 3'd6; A = 16'h0003; B = 16'h0005;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_R", R, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    macc = '0; last_r = '0; last_ovf = 1'b0;
    repeat (20) idle();
    run_op(3'd4, 16'h0000, 16'h0000);
    chk("acc_after_rst", R, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
